// File: rtl/fast_conf_parser.sv
// FAST configuration packet parser: turns TCM write / CPU select / CPU start commands
// into strobes and answers TCM read commands with a four-flit FAST response packet.
module fast_conf_parser (
    input  logic         clk,
    input  logic         reset,
    input  logic         data_in_valid,
    input  logic [133:0] data_in,
    output logic         conf_wren,
    output logic [31:0]  conf_addr,
    output logic [31:0]  conf_wdata,
    output logic         conf_sel,
    output logic         cpu_start,
    output logic         mem_rden,
    output logic [31:0]  mem_raddr,
    input  logic [31:0]  mem_rdata,
    output logic         data_out_valid,
    output logic [133:0] data_out,
    output logic [15:0]  err_cnt
);

    // Input stream handshake: a flit is consumed on every cycle data_in_valid is high;
    // there is no ready, so the parser never stalls. data_out_valid marks each response
    // flit for exactly one cycle and is likewise never held off.

    localparam logic [1:0]  TAG_HEAD   = 2'b01;
    localparam logic [1:0]  TAG_MID    = 2'b11;
    localparam logic [1:0]  TAG_TAIL   = 2'b10;

    localparam logic [15:0] CMD_SEL    = 16'h9001;
    localparam logic [15:0] CMD_START  = 16'h9002;
    localparam logic [15:0] CMD_WRITE  = 16'h9003;
    localparam logic [15:0] CMD_READ   = 16'h9004;
    localparam logic [15:0] CMD_RESP   = 16'h9005;

    typedef enum logic [2:0] {
        IDLE,
        META,
        TYPE,
        PAYLOAD,
        DROP
    } parser_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_WAIT,
        R_HEAD,
        R_META,
        R_TYPE,
        R_DATA
    } resp_state_t;

    parser_state_t p_state_q, p_state_d;
    resp_state_t   r_state_q, r_state_d;

    logic [15:0] type_q,       type_d;
    logic        first_q,      first_d;
    logic        wren_q,       wren_d;
    logic [31:0] addr_q,       addr_d;
    logic [31:0] wdata_q,      wdata_d;
    logic        sel_q,        sel_d;
    logic        start_q,      start_d;
    logic        rden_q,       rden_d;
    logic [31:0] raddr_q,      raddr_d;
    logic [15:0] err_q,        err_d;
    logic [31:0] rdata_q,      rdata_d;
    logic [31:0] resp_addr_q,  resp_addr_d;

    logic        err_inc;
    logic        resp_busy;

    logic [1:0]  in_tag;
    logic        in_head;
    logic        in_tail;
    logic        in_body;
    logic [15:0] in_type;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        unused_bits;

    assign in_tag   = data_in[133:132];
    assign in_head  = (in_tag == TAG_HEAD);
    assign in_tail  = (in_tag == TAG_TAIL);
    assign in_body  = (in_tag == TAG_MID) || in_tail;
    assign in_type  = data_in[31:16];
    assign in_addr  = data_in[47:16];
    assign in_wdata = data_in[79:48];

    assign unused_bits = ^{data_in[131:128], data_in[127:80], data_in[15:0]};

    // The R_DATA cycle is not busy: its slot returns to R_IDLE in time to take a new request.
    assign resp_busy = rden_q ||
                       (r_state_q == R_WAIT) || (r_state_q == R_HEAD) ||
                       (r_state_q == R_META) || (r_state_q == R_TYPE);

    always_comb begin
        p_state_d = p_state_q;
        type_d    = type_q;
        first_d   = first_q;
        wren_d    = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        start_d   = 1'b0;
        rden_d    = 1'b0;
        raddr_d   = raddr_q;
        err_inc   = 1'b0;

        if (data_in_valid) begin
            if (in_head) begin
                if (p_state_q != IDLE) begin
                    err_inc = 1'b1;
                end
                p_state_d = META;
            end else begin
                unique case (p_state_q)
                    IDLE: begin
                        if (in_body) begin
                            err_inc = 1'b1;
                        end
                    end
                    META: begin
                        if (in_tail) begin
                            err_inc   = 1'b1;
                            p_state_d = IDLE;
                        end else if (in_body) begin
                            p_state_d = TYPE;
                        end
                    end
                    TYPE: begin
                        type_d = in_type;
                        if (in_tail) begin
                            err_inc   = 1'b1;
                            p_state_d = IDLE;
                        end else if (in_body) begin
                            first_d = 1'b1;
                            if ((in_type == CMD_SEL)   || (in_type == CMD_START) ||
                                (in_type == CMD_WRITE) || (in_type == CMD_READ)) begin
                                p_state_d = PAYLOAD;
                            end else begin
                                p_state_d = DROP;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (in_body) begin
                            first_d = 1'b0;
                            case (type_q)
                                CMD_WRITE: begin
                                    wren_d  = 1'b1;
                                    addr_d  = in_addr;
                                    wdata_d = in_wdata;
                                end
                                CMD_SEL: begin
                                    if (first_q) begin
                                        sel_d = data_in[16];
                                    end
                                end
                                CMD_START: begin
                                    if (in_tail) begin
                                        start_d = 1'b1;
                                    end
                                end
                                CMD_READ: begin
                                    if (first_q) begin
                                        if (resp_busy) begin
                                            err_inc = 1'b1;
                                        end else begin
                                            rden_d  = 1'b1;
                                            raddr_d = in_addr;
                                        end
                                    end
                                end
                                default: begin
                                end
                            endcase
                            if (in_tail) begin
                                p_state_d = IDLE;
                            end
                        end
                    end
                    DROP: begin
                        if (in_tail) begin
                            p_state_d = IDLE;
                        end
                    end
                    default: begin
                        p_state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (err_inc && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    always_comb begin
        r_state_d   = r_state_q;
        rdata_d     = rdata_q;
        resp_addr_d = resp_addr_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (rden_q) begin
                    r_state_d   = R_WAIT;
                    resp_addr_d = raddr_q;
                end
            end
            R_WAIT: begin
                rdata_d   = mem_rdata;
                r_state_d = R_HEAD;
            end
            R_HEAD:  r_state_d = R_META;
            R_META:  r_state_d = R_TYPE;
            R_TYPE:  r_state_d = R_DATA;
            R_DATA:  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Response flits decode straight from the responder state register.
    always_comb begin
        data_out_valid = 1'b0;
        data_out       = '0;
        unique case (r_state_q)
            R_HEAD: begin
                data_out_valid = 1'b1;
                data_out       = {TAG_HEAD, 132'b0};
            end
            R_META: begin
                data_out_valid = 1'b1;
                data_out       = {TAG_MID, 132'b0};
            end
            R_TYPE: begin
                data_out_valid = 1'b1;
                data_out       = {TAG_MID, 4'b0, 96'b0, CMD_RESP, 16'b0};
            end
            R_DATA: begin
                data_out_valid = 1'b1;
                data_out       = {TAG_TAIL, 4'b0, 48'b0, rdata_q, resp_addr_q, 16'b0};
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_state_q   <= IDLE;
            r_state_q   <= R_IDLE;
            type_q      <= '0;
            first_q     <= 1'b0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= 1'b0;
            start_q     <= 1'b0;
            rden_q      <= 1'b0;
            raddr_q     <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            resp_addr_q <= '0;
        end else begin
            p_state_q   <= p_state_d;
            r_state_q   <= r_state_d;
            type_q      <= type_d;
            first_q     <= first_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            start_q     <= start_d;
            rden_q      <= rden_d;
            raddr_q     <= raddr_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            resp_addr_q <= resp_addr_d;
        end
    end

    assign conf_wren  = wren_q;
    assign conf_addr  = addr_q;
    assign conf_wdata = wdata_q;
    assign conf_sel   = sel_q;
    assign cpu_start  = start_q;
    assign mem_rden   = rden_q;
    assign mem_raddr  = raddr_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_fast_conf_parser.sv
// Directed bench for fast_conf_parser: vector table for framing/command decode,
// hand-written sequences for the write burst, read responses and mid-response reset.
module tb_fast_conf_parser;

    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] M = 2'b11;
    localparam logic [1:0] T = 2'b10;

    logic         clk = 1'b0;
    logic         reset;
    logic         data_in_valid;
    logic [133:0] data_in;
    logic         conf_wren;
    logic [31:0]  conf_addr;
    logic [31:0]  conf_wdata;
    logic         conf_sel;
    logic         cpu_start;
    logic         mem_rden;
    logic [31:0]  mem_raddr;
    logic [31:0]  mem_rdata;
    logic         data_out_valid;
    logic [133:0] data_out;
    logic [15:0]  err_cnt;

    always #5 clk = ~clk;

    fast_conf_parser dut (
        .clk            (clk),
        .reset          (reset),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .conf_wren      (conf_wren),
        .conf_addr      (conf_addr),
        .conf_wdata     (conf_wdata),
        .conf_sel       (conf_sel),
        .cpu_start      (cpu_start),
        .mem_rden       (mem_rden),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .err_cnt        (err_cnt)
    );

    typedef struct {
        logic         v;
        logic [1:0]   tag;
        logic [127:0] pl;
        logic         wren;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic         sel;
        logic         start;
        logic [15:0]  err;
    } vec_t;

    vec_t         vecs[$];
    logic [133:0] exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           resp_seen = 0;

    function automatic logic [31:0] tcm_word(input logic [31:0] a);
        return (a == 32'd128) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
    endfunction

    // TCM model: read data appears the cycle after mem_rden.
    always @(posedge clk) mem_rdata <= mem_rden ? tcm_word(mem_raddr) : 32'h0;

    function automatic logic [127:0] pw(input logic [31:0] a, input logic [31:0] d);
        return {48'b0, d, a, 16'b0};
    endfunction

    function automatic logic [127:0] pt(input logic [15:0] t);
        return {96'b0, t, 16'b0};
    endfunction

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_resp(input logic [31:0] a);
        exp_q.push_back({2'b01, 132'b0});
        exp_q.push_back({2'b11, 132'b0});
        exp_q.push_back({2'b11, 4'b0, 96'b0, 16'h9005, 16'b0});
        exp_q.push_back({2'b10, 4'b0, 48'b0, tcm_word(a), a, 16'b0});
    endtask

    always @(negedge clk) begin
        if (data_out_valid === 1'b1) begin
            resp_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_unexpected: got %h, required no flit", data_out);
            end else begin
                check("resp_flit", data_out, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] tag, input logic [127:0] pl);
        @(negedge clk);
        data_in_valid = v;
        data_in       = {tag, 4'b0, pl};
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        data_in_valid = 1'b0;
        data_in       = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic add(input logic v, input logic [1:0] tag, input logic [127:0] pl,
                       input logic wren, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic sel, input logic start, input logic [15:0] err);
        vec_t r;
        r.v = v; r.tag = tag; r.pl = pl; r.wren = wren; r.addr = addr; r.wdata = wdata;
        r.sel = sel; r.start = start; r.err = err;
        vecs.push_back(r);
    endtask

    task automatic send_read(input logic [31:0] a, input logic busy_exp, input string name);
        step(1'b1, H, '0);
        step(1'b1, M, '0);
        step(1'b1, M, pt(16'h9004));
        step(1'b1, M, pw(a, 32'h0));
        check({name, "_rden"}, mem_rden, !busy_exp);
        if (!busy_exp) check({name, "_raddr"}, mem_raddr, a);
        step(1'b1, M, '0);
        step(1'b1, T, '0);
    endtask

    initial begin
        logic [127:0] sel_one;
        int           base;
        sel_one = 128'h1_0000;

        reset         = 1'b1;
        data_in_valid = 1'b0;
        data_in       = '0;
        do_reset();
        check("rst_wren",  conf_wren, 1'b0);
        check("rst_addr",  conf_addr, 32'h0);
        check("rst_wdata", conf_wdata, 32'h0);
        check("rst_sel",   conf_sel, 1'b0);
        check("rst_start", cpu_start, 1'b0);
        check("rst_rden",  mem_rden, 1'b0);
        check("rst_raddr", mem_raddr, 32'h0);
        check("rst_dov",   data_out_valid, 1'b0);
        check("rst_dout",  data_out, 134'h0);
        check("rst_err",   err_cnt, 16'h0);

        // middle flit in IDLE
        add(1, M, '0,                           0, 0, 0,            0, 0, 1);
        // short write packet
        add(1, H, '0,                           0, 0, 0,            0, 0, 1);
        add(1, M, '0,                           0, 0, 0,            0, 0, 1);
        add(1, M, pt(16'h9003),                 0, 0, 0,            0, 0, 1);
        add(1, M, pw(10, 32'h1111_0001),        1, 10, 32'h1111_0001, 0, 0, 1);
        add(1, M, pw(11, 32'h2222_0002),        1, 11, 32'h2222_0002, 0, 0, 1);
        add(1, T, pw(12, 32'h3333_0003),        1, 12, 32'h3333_0003, 0, 0, 1);
        // write packet with gaps
        add(1, H, '0,                           0, 0, 0,            0, 0, 1);
        add(1, M, '0,                           0, 0, 0,            0, 0, 1);
        add(1, M, pt(16'h9003),                 0, 0, 0,            0, 0, 1);
        add(0, M, pw(99, 32'h9999_9999),        0, 0, 0,            0, 0, 1);
        add(1, M, pw(20, 32'hCAFE_0020),        1, 20, 32'hCAFE_0020, 0, 0, 1);
        add(0, T, pw(98, 32'h9898_9898),        0, 0, 0,            0, 0, 1);
        add(1, T, pw(21, 32'hCAFE_0021),        1, 21, 32'hCAFE_0021, 0, 0, 1);
        // select on, later flit ignored
        add(1, H, '0,                           0, 0, 0,            0, 0, 1);
        add(1, M, '0,                           0, 0, 0,            0, 0, 1);
        add(1, M, pt(16'h9001),                 0, 0, 0,            0, 0, 1);
        add(1, M, sel_one,                      0, 0, 0,            1, 0, 1);
        add(1, T, '0,                           0, 0, 0,            1, 0, 1);
        // select off from a tail-only payload
        add(1, H, '0,                           0, 0, 0,            1, 0, 1);
        add(1, M, '0,                           0, 0, 0,            1, 0, 1);
        add(1, M, pt(16'h9001),                 0, 0, 0,            1, 0, 1);
        add(1, T, '0,                           0, 0, 0,            0, 0, 1);
        // start pulse on tail only
        add(1, H, '0,                           0, 0, 0,            0, 0, 1);
        add(1, M, '0,                           0, 0, 0,            0, 0, 1);
        add(1, M, pt(16'h9002),                 0, 0, 0,            0, 0, 1);
        add(1, M, pw(5, 32'h5),                 0, 0, 0,            0, 0, 1);
        add(1, T, '0,                           0, 0, 0,            0, 1, 1);
        add(0, M, '0,                           0, 0, 0,            0, 0, 1);
        // unknown type discarded
        add(1, H, '0,                           0, 0, 0,            0, 0, 1);
        add(1, M, '0,                           0, 0, 0,            0, 0, 1);
        add(1, M, pt(16'h1234),                 0, 0, 0,            0, 0, 1);
        add(1, M, pw(40, 32'h4040_4040),        0, 0, 0,            0, 0, 1);
        add(1, T, pw(41, 32'h4141_4141),        0, 0, 0,            0, 0, 1);
        // head aborts a write packet
        add(1, H, '0,                           0, 0, 0,            0, 0, 1);
        add(1, M, '0,                           0, 0, 0,            0, 0, 1);
        add(1, M, pt(16'h9003),                 0, 0, 0,            0, 0, 1);
        add(1, M, pw(30, 32'hAAAA_0030),        1, 30, 32'hAAAA_0030, 0, 0, 1);
        add(1, H, pw(77, 32'h7777_7777),        0, 0, 0,            0, 0, 2);
        add(1, M, '0,                           0, 0, 0,            0, 0, 2);
        add(1, M, pt(16'h9003),                 0, 0, 0,            0, 0, 2);
        add(1, M, pw(31, 32'hBBBB_0031),        1, 31, 32'hBBBB_0031, 0, 0, 2);
        add(1, T, pw(32, 32'hCCCC_0032),        1, 32, 32'hCCCC_0032, 0, 0, 2);
        // tail in META, tail in TYPE, tail in IDLE
        add(1, H, '0,                           0, 0, 0,            0, 0, 2);
        add(1, T, '0,                           0, 0, 0,            0, 0, 3);
        add(1, H, '0,                           0, 0, 0,            0, 0, 3);
        add(1, M, '0,                           0, 0, 0,            0, 0, 3);
        add(1, T, pt(16'h9003),                 0, 0, 0,            0, 0, 4);
        add(1, T, '0,                           0, 0, 0,            0, 0, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].tag, vecs[i].pl);
            check($sformatf("vec%0d_ctl", i),
                  {conf_wren, conf_sel, cpu_start, mem_rden, data_out_valid, err_cnt},
                  {vecs[i].wren, vecs[i].sel, vecs[i].start, 1'b0, 1'b0, vecs[i].err});
            if (vecs[i].wren) begin
                check($sformatf("vec%0d_wr", i), {conf_addr, conf_wdata},
                      {vecs[i].addr, vecs[i].wdata});
            end
        end

        // 2001-flit write burst
        do_reset();
        step(1'b1, H, '0);
        step(1'b1, M, '0);
        step(1'b1, M, pt(16'h9003));
        for (int i = 0; i <= 2000; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = i;
            d = {a[15:0], ~a[15:0]};
            step(1'b1, (i == 2000) ? T : M, pw(a, d));
            check($sformatf("burst%0d", i), {conf_wren, conf_addr, conf_wdata}, {1'b1, a, d});
        end
        step(1'b0, M, '0);
        check("burst_end", {conf_wren, err_cnt}, {1'b0, 16'h0});

        // single read with response timing
        do_reset();
        push_resp(32'd128);
        step(1'b1, H, '0);
        step(1'b1, M, '0);
        step(1'b1, M, pt(16'h9004));
        step(1'b1, M, pw(32'd128, 32'h0));
        check("rd1_rden", {mem_rden, mem_raddr}, {1'b1, 32'd128});
        step(1'b1, T, '0);
        check("rd1_wait", {mem_rden, data_out_valid}, 2'b00);
        step(1'b0, M, '0);
        check("rd1_head", {data_out_valid, data_out}, {1'b1, 2'b01, 132'b0});
        step(1'b0, M, '0);
        step(1'b0, M, '0);
        step(1'b0, M, '0);
        check("rd1_tail", {data_out_valid, data_out[133:132], data_out[79:48], data_out[47:16]},
              {1'b1, 2'b10, 32'hDEADBEEF, 32'd128});
        step(1'b0, M, '0);
        check("rd1_done", data_out_valid, 1'b0);

        // two back-to-back 6-flit reads
        base = resp_seen;
        push_resp(32'h200);
        push_resp(32'h344);
        send_read(32'h200, 1'b0, "b2b_a");
        send_read(32'h344, 1'b0, "b2b_b");
        repeat (8) step(1'b0, M, '0);
        check("b2b_flits", resp_seen - base, 8);
        check("b2b_err", err_cnt, 16'h0);

        // read arriving while the responder is busy is dropped
        push_resp(32'h50);
        step(1'b1, H, '0);
        step(1'b1, M, '0);
        step(1'b1, M, pt(16'h9004));
        step(1'b1, T, pw(32'h50, 32'h0));
        check("busy_a_rden", {mem_rden, mem_raddr}, {1'b1, 32'h50});
        step(1'b1, H, '0);
        step(1'b1, M, '0);
        step(1'b1, M, pt(16'h9004));
        step(1'b1, T, pw(32'h60, 32'h0));
        check("busy_b_drop", {mem_rden, err_cnt}, {1'b0, 16'h1});
        repeat (6) step(1'b0, M, '0);
        check("busy_err", err_cnt, 16'h1);

        // reset in the middle of a response
        step(1'b1, H, '0);
        step(1'b1, M, '0);
        step(1'b1, M, pt(16'h9001));
        step(1'b1, T, sel_one);
        check("rst_pre_sel", conf_sel, 1'b1);
        push_resp(32'h70);
        step(1'b1, H, '0);
        step(1'b1, M, '0);
        step(1'b1, M, pt(16'h9004));
        step(1'b1, T, pw(32'h70, 32'h0));
        check("rst_rd_rden", mem_rden, 1'b1);
        step(1'b0, M, '0);
        step(1'b0, M, '0);
        check("rst_rd_head", data_out_valid, 1'b1);
        @(negedge clk);
        reset         = 1'b1;
        data_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_dov", data_out_valid, 1'b0);
        check("rst_mid_outs",
              {conf_wren, conf_addr, conf_wdata, conf_sel, cpu_start, mem_rden, mem_raddr,
               data_out, err_cnt}, '0);
        check("rst_mid_left", exp_q.size(), 3);
        exp_q.delete();
        reset = 1'b0;
        repeat (6) step(1'b0, M, '0);
        check("rst_mid_quiet", data_out_valid, 1'b0);

        check("resp_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
